// File: rtl/decode_stage.sv
// MIPS instruction-decode pipeline stage: splits the instruction into fields, builds the
// extended immediate and write enable, and handles valid/ready, flush and load-use stalls.
module decode_stage #(
    parameter int WIDTH     = 32,
    parameter int LINK_REG  = 31,
    parameter int HAZARD_EN = 1,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [31:0]          ir_i,
    input  logic [WIDTH-1:0]     pc_i,
    input  logic                 flush_i,
    input  logic                 ex_load_i,
    input  logic [4:0]           ex_rt_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [5:0]           opcode_o,
    output logic [4:0]           rs_o,
    output logic [4:0]           rt_o,
    output logic [4:0]           rd_o,
    output logic [4:0]           shamt_o,
    output logic [5:0]           funct_o,
    output logic [WIDTH-1:0]     imm_o,
    output logic                 we_o,
    output logic [WIDTH-1:0]     pc_o,
    output logic [CNT_WIDTH-1:0] stall_cnt_o
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    // Opcodes that read rt as a source (R-type, branches, stores)
    localparam int          N_USES_RT = 6;
    localparam logic [5:0]  USES_RT_OPS [N_USES_RT] = '{6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B};

    // ------------------------------------------------------------------
    // Field split of the incoming instruction
    // ------------------------------------------------------------------
    logic [5:0]  ir_opcode;
    logic [4:0]  ir_rs;
    logic [4:0]  ir_rt;
    logic [4:0]  ir_rd;
    logic [4:0]  ir_shamt;
    logic [5:0]  ir_funct;
    logic [15:0] ir_imm16;

    assign ir_opcode = ir_i[31:26];
    assign ir_rs     = ir_i[25:21];
    assign ir_rt     = ir_i[20:16];
    assign ir_rd     = ir_i[15:11];
    assign ir_shamt  = ir_i[10:6];
    assign ir_funct  = ir_i[5:0];
    assign ir_imm16  = ir_i[15:0];

    logic [N_USES_RT-1:0] uses_rt_hit;
    logic                 uses_rt;

    genvar gi;
    generate
        for (gi = 0; gi < N_USES_RT; gi++) begin : g_uses_rt
            assign uses_rt_hit[gi] = (ir_opcode == USES_RT_OPS[gi]);
        end
    endgenerate

    assign uses_rt = |uses_rt_hit;

    // ------------------------------------------------------------------
    // Destination register, immediate and write enable
    // ------------------------------------------------------------------
    logic [4:0]       dec_rd;
    logic [WIDTH-1:0] imm_sext;
    logic [WIDTH-1:0] imm_zext;
    logic [WIDTH-1:0] imm_lui;
    logic [WIDTH-1:0] dec_imm;
    logic             dec_we_raw;
    logic             dec_we;

    always_comb begin
        dec_rd = ir_rt;
        if (ir_opcode == OP_RTYPE) begin
            dec_rd = ir_rd;
        end else if (ir_opcode == OP_JAL) begin
            dec_rd = 5'(LINK_REG);
        end
    end

    assign imm_sext = {{(WIDTH-16){ir_imm16[15]}}, ir_imm16};
    assign imm_zext = {{(WIDTH-16){1'b0}}, ir_imm16};
    // Shifting the sign-extended value leaves bit 31 replicated above it for WIDTH > 32
    assign imm_lui  = imm_sext << 16;

    always_comb begin
        dec_imm = imm_sext;
        case (ir_opcode)
            OP_ANDI, OP_ORI, OP_XORI: dec_imm = imm_zext;
            OP_LUI:                   dec_imm = imm_lui;
            default:                  dec_imm = imm_sext;
        endcase
    end

    always_comb begin
        dec_we_raw = 1'b0;
        case (ir_opcode)
            OP_RTYPE: dec_we_raw = (ir_funct != FUNCT_JR);
            OP_JAL:   dec_we_raw = 1'b1;
            default:  dec_we_raw = ir_opcode inside {[6'h08:6'h0F], [6'h20:6'h25]};
        endcase
    end

    assign dec_we = dec_we_raw && (dec_rd != 5'd0);

    // ------------------------------------------------------------------
    // Load-use hazard detection
    // ------------------------------------------------------------------
    logic hazard;

    generate
        if (HAZARD_EN != 0) begin : g_hazard
            assign hazard = ex_load_i && (ex_rt_i != 5'd0) &&
                            ((ex_rt_i == ir_rs) || (uses_rt && (ex_rt_i == ir_rt)));
        end else begin : g_no_hazard
            assign hazard = 1'b0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake and state
    // ------------------------------------------------------------------
    logic                 valid_q,     valid_d;
    logic [5:0]           opcode_q,    opcode_d;
    logic [4:0]           rs_q,        rs_d;
    logic [4:0]           rt_q,        rt_d;
    logic [4:0]           rd_q,        rd_d;
    logic [4:0]           shamt_q,     shamt_d;
    logic [5:0]           funct_q,     funct_d;
    logic [WIDTH-1:0]     imm_q,       imm_d;
    logic                 we_q,        we_d;
    logic [WIDTH-1:0]     pc_q,        pc_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;

    logic transfer;
    logic stall_event;

    assign ready_o     = !rst_i && (flush_i || ((!valid_q || ready_i) && !hazard));
    assign transfer    = valid_i && ready_o && !flush_i;
    assign stall_event = valid_i && hazard && !flush_i;

    always_comb begin
        valid_d     = valid_q;
        opcode_d    = opcode_q;
        rs_d        = rs_q;
        rt_d        = rt_q;
        rd_d        = rd_q;
        shamt_d     = shamt_q;
        funct_d     = funct_q;
        imm_d       = imm_q;
        we_d        = we_q;
        pc_d        = pc_q;
        stall_cnt_d = stall_cnt_q;

        if (flush_i) begin
            valid_d = 1'b0;
        end else if (transfer) begin
            valid_d  = 1'b1;
            opcode_d = ir_opcode;
            rs_d     = ir_rs;
            rt_d     = ir_rt;
            rd_d     = dec_rd;
            shamt_d  = ir_shamt;
            funct_d  = ir_funct;
            imm_d    = dec_imm;
            we_d     = dec_we;
            pc_d     = pc_i;
        end else if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if (stall_event && (stall_cnt_q != {CNT_WIDTH{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            opcode_q    <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            shamt_q     <= '0;
            funct_q     <= '0;
            imm_q       <= '0;
            we_q        <= 1'b0;
            pc_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            valid_q     <= valid_d;
            opcode_q    <= opcode_d;
            rs_q        <= rs_d;
            rt_q        <= rt_d;
            rd_q        <= rd_d;
            shamt_q     <= shamt_d;
            funct_q     <= funct_d;
            imm_q       <= imm_d;
            we_q        <= we_d;
            pc_q        <= pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign valid_o     = valid_q;
    assign opcode_o    = opcode_q;
    assign rs_o        = rs_q;
    assign rt_o        = rt_q;
    assign rd_o        = rd_q;
    assign shamt_o     = shamt_q;
    assign funct_o     = funct_q;
    assign imm_o       = imm_q;
    assign we_o        = we_q;
    assign pc_o        = pc_q;
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Randomized scoreboard bench for decode_stage: a stimulus process predicts each decode from
// the instruction-set rules and queues it; a monitor compares whatever the stage presents.
module tb_decode_stage;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          valid_i;
    logic          ready_o;
    logic [31:0]   ir_i;
    logic [31:0]   pc_i;
    logic          flush_i;
    logic          ex_load_i;
    logic [4:0]    ex_rt_i;
    logic          valid_o;
    logic          ready_i;
    logic [5:0]    opcode_o;
    logic [4:0]    rs_o;
    logic [4:0]    rt_o;
    logic [4:0]    rd_o;
    logic [4:0]    shamt_o;
    logic [5:0]    funct_o;
    logic [31:0]   imm_o;
    logic          we_o;
    logic [31:0]   pc_o;
    logic [CW-1:0] stall_cnt_o;

    decode_stage #(
        .WIDTH     (32),
        .LINK_REG  (31),
        .HAZARD_EN (1),
        .CNT_WIDTH (CW)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .ir_i        (ir_i),
        .pc_i        (pc_i),
        .flush_i     (flush_i),
        .ex_load_i   (ex_load_i),
        .ex_rt_i     (ex_rt_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .opcode_o    (opcode_o),
        .rs_o        (rs_o),
        .rt_o        (rt_o),
        .rd_o        (rd_o),
        .shamt_o     (shamt_o),
        .funct_o     (funct_o),
        .imm_o       (imm_o),
        .we_o        (we_o),
        .pc_o        (pc_o),
        .stall_cnt_o (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [31:0] imm;
        logic        we;
        logic [31:0] pc;
    } dec_t;

    dec_t exp_q[$];
    dec_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   model_valid = 1'b0;
    bit   model_known = 1'b0;
    int   model_cnt   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic bit ref_uses_rt(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h04) || (op == 6'h05) ||
               (op == 6'h28) || (op == 6'h29) || (op == 6'h2B);
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] ir, input logic [31:0] pc);
        dec_t d;
        int   opn;
        d.op    = ir[31:26];
        d.rs    = ir[25:21];
        d.rt    = ir[20:16];
        d.shamt = ir[10:6];
        d.funct = ir[5:0];
        d.pc    = pc;
        opn     = int'(d.op);
        if (opn == 0)      d.rd = ir[15:11];
        else if (opn == 3) d.rd = 5'd31;
        else               d.rd = ir[20:16];
        if (opn >= 12 && opn <= 14)
            d.imm = {16'h0000, ir[15:0]};
        else if (opn == 15)
            d.imm = 32'(ir[15:0]) * 32'd65536;
        else
            d.imm = (ir[15] ? 32'hFFFF_0000 : 32'h0) | 32'(ir[15:0]);
        if (opn == 0)
            d.we = (d.funct != 6'h08);
        else
            d.we = (opn == 3) || (opn >= 8 && opn <= 15) || (opn >= 32 && opn <= 37);
        if (d.rd == 5'd0) d.we = 1'b0;
        return d;
    endfunction

    // One clock of stimulus; the model's predictions are made against the spec rules.
    task automatic step(input bit rst, input bit v, input logic [31:0] ir, input logic [31:0] pc,
                        input bit fl, input bit ld, input logic [4:0] ert, input bit rdy);
        bit haz;
        bit rdy_exp;
        bit drop;
        rst_i     = rst;
        valid_i   = v;
        ir_i      = ir;
        pc_i      = pc;
        flush_i   = fl;
        ex_load_i = ld;
        ex_rt_i   = ert;
        ready_i   = rdy;
        #1;
        haz = ld && (ert != 5'd0) &&
              ((ert == ir[25:21]) || (ref_uses_rt(ir[31:26]) && (ert == ir[20:16])));
        rdy_exp = !rst && (fl || ((!model_valid || rdy) && !haz));
        check("ready_o", 32'(ready_o), 32'(rdy_exp));
        if (model_known) begin
            check("valid_o", 32'(valid_o), 32'(model_valid));
            check("stall_cnt_o", 32'(stall_cnt_o), 32'(model_cnt));
        end
        drop = 1'b0;
        if (rst) begin
            model_valid = 1'b0;
            model_cnt   = 0;
        end else begin
            if (v && haz && !fl && model_cnt < CNT_MAX) model_cnt++;
            if (fl) begin
                drop        = model_valid && !rdy;
                model_valid = 1'b0;
            end else if (v && rdy_exp) begin
                exp_q.push_back(ref_decode(ir, pc));
                model_valid = 1'b1;
            end else if (model_valid && rdy) begin
                model_valid = 1'b0;
            end
        end
        @(posedge clk_i);
        if (rst) exp_q.delete();
        else if (drop) void'(exp_q.pop_front());
        model_known = 1'b1;
        #1;
    endtask

    always @(negedge clk_i) begin
        if (!rst_i && valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid_o=1 required no pending instruction at %0t", $time);
            end else begin
                mon_e = exp_q[0];
                check("opcode_o", 32'(opcode_o), 32'(mon_e.op));
                check("rs_o",     32'(rs_o),     32'(mon_e.rs));
                check("rt_o",     32'(rt_o),     32'(mon_e.rt));
                check("rd_o",     32'(rd_o),     32'(mon_e.rd));
                check("shamt_o",  32'(shamt_o),  32'(mon_e.shamt));
                check("funct_o",  32'(funct_o),  32'(mon_e.funct));
                check("imm_o",    imm_o,         mon_e.imm);
                check("we_o",     32'(we_o),     32'(mon_e.we));
                check("pc_o",     pc_o,          mon_e.pc);
                if (ready_i) void'(exp_q.pop_front());
            end
        end
    end

    localparam logic [31:0] ADDU  = 32'h0085_1821;
    localparam logic [31:0] ORI   = 32'h3482_8001;
    localparam logic [31:0] ADDIU = 32'h2482_8001;
    localparam logic [31:0] LUI   = 32'h3C02_1234;
    localparam logic [31:0] JAL   = 32'h0C00_0010;

    logic [5:0] ops [20] = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0C,
                             6'h0D, 6'h0E, 6'h0F, 6'h20, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2B};

    initial begin
        logic [5:0]  r_op;
        logic [4:0]  r_rd;
        logic [5:0]  r_funct;
        logic [31:0] r_ir;
        rst_i = 1'b1; valid_i = 1'b0; ir_i = '0; pc_i = '0; flush_i = 1'b0;
        ex_load_i = 1'b0; ex_rt_i = '0; ready_i = 1'b0;

        // Reset held two cycles with an instruction offered
        step(1, 1, ADDU, 32'h0, 0, 0, 0, 1);
        step(1, 1, ADDU, 32'h0, 0, 0, 0, 1);

        // Basic decodes with execute always ready
        step(0, 1, ADDU,  32'h100, 0, 0, 0, 1);
        step(0, 0, 32'h0, 32'h0,   0, 0, 0, 1);
        step(0, 1, ORI,   32'h104, 0, 0, 0, 1);
        step(0, 1, ADDIU, 32'h108, 0, 0, 0, 1);
        step(0, 1, LUI,   32'h10C, 0, 0, 0, 1);
        step(0, 0, 32'h0, 32'h0,   0, 0, 0, 1);

        // Load-use stall then release
        step(0, 1, ADDU,  32'h110, 0, 1, 5'd4, 1);
        step(0, 1, ADDU,  32'h110, 0, 0, 5'd4, 1);
        step(0, 0, 32'h0, 32'h0,   0, 0, 0, 1);

        // Backpressure for three cycles, then accept on release
        step(0, 1, ADDU, 32'h114, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) step(0, 1, ORI, 32'h118, 0, 0, 0, 0);
        step(0, 1, ORI,   32'h118, 0, 0, 0, 1);
        step(0, 0, 32'h0, 32'h0,   0, 0, 0, 1);

        // Flush while holding, then JAL without flush
        step(0, 1, LUI,   32'h11C, 0, 0, 0, 1);
        step(0, 1, JAL,   32'h120, 1, 0, 0, 0);
        step(0, 0, 32'h0, 32'h0,   0, 0, 0, 1);
        step(0, 1, JAL,   32'h124, 0, 0, 0, 1);
        step(0, 0, 32'h0, 32'h0,   0, 0, 0, 1);

        // Hold a hazard long enough to saturate the stall counter
        for (int i = 0; i < CNT_MAX + 4; i++) step(0, 1, ADDU, 32'h128, 0, 1, 5'd5, 1);
        check("stall_cnt_saturated", 32'(stall_cnt_o), 32'(CNT_MAX));
        step(0, 1, ADDU,  32'h128, 0, 0, 0, 1);
        step(0, 0, 32'h0, 32'h0,   0, 0, 0, 1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            r_op    = ($urandom % 5 == 0) ? 6'($urandom) : ops[$urandom % 20];
            r_rd    = ($urandom % 4 == 0) ? 5'd0 : 5'($urandom);
            r_funct = ($urandom % 4 == 0) ? 6'h08 : 6'($urandom);
            r_ir    = {r_op, 5'($urandom % 8), 5'($urandom % 8), r_rd, 5'($urandom), r_funct};
            step(($urandom % 300) == 0, ($urandom % 4) != 0, r_ir, $urandom & 32'hFFFF_FFFC,
                 ($urandom % 12) == 0, ($urandom % 3) == 0, 5'($urandom % 8), ($urandom % 4) != 0);
        end

        // Drain whatever is still held
        for (int i = 0; i < 20 && (model_valid || exp_q.size() != 0); i++)
            step(0, 0, 32'h0, 32'h0, 0, 0, 0, 1);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
